alu_reg_stage: RTL and testbench

Operand and result register stage wrapped around the combinational 16-bit ALU of the SAP datapath. It holds the accumulator (A) and operand register (B), which drive the ALU inputs. It registers the ALU opcode and writes the 17-bit ALU result back into A together with carry, zero and negative flags. A small sequencer gives the control unit a start/busy/done handshake per operation.

---
 rtl/alu_reg_stage_if.sv | 33 +++
 rtl/alu_reg_stage.sv | 108 ++++++++++
 tb/tb_alu_reg_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_reg_stage_if.sv
// Control and datapath signal bundle between the control unit, the ALU
// and the accumulator/operand register stage.
interface alu_reg_stage_if;
    logic [15:0] bus_in;
    logic        ld_a;
    logic        exec;
    logic [3:0]  exec_op;
    logic [16:0] alu_res;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] acc_out;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;
    logic        busy;
    logic        done;
    logic        err;

    // Control unit / ALU side: drives bus, commands and the ALU result.
    modport master (
        output bus_in, ld_a, exec, exec_op, alu_res,
        input  alu_a, alu_b, alu_op, acc_out,
        input  flag_c, flag_z, flag_n, busy, done, err
    );

    // Register stage side.
    modport slave (
        input  bus_in, ld_a, exec, exec_op, alu_res,
        output alu_a, alu_b, alu_op, acc_out,
        output flag_c, flag_z, flag_n, busy, done, err
    );
endinterface

// File: rtl/alu_reg_stage.sv
// Accumulator (A), operand (B) and opcode registers around the SAP ALU,
// with an IDLE/CALC/DONE sequencer providing a start/busy/done handshake.
module alu_reg_stage (
    input  logic             clk,
    input  logic             rst,
    alu_reg_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_calc = 2'd1,
        st_done = 2'd2
    } state_t;

    state_t      state_reg,  state_next;
    logic [15:0] a_reg,      a_next;
    logic [15:0] b_reg,      b_next;
    logic [3:0]  op_reg,     op_next;
    logic        c_reg,      c_next;
    logic        z_reg,      z_next;
    logic        n_reg,      n_next;
    logic        busy_reg,   busy_next;
    logic        done_reg,   done_next;
    logic        err_reg,    err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= st_idle;
            a_reg     <= 16'h0000;
            b_reg     <= 16'h0000;
            op_reg    <= 4'h0;
            c_reg     <= 1'b0;
            z_reg     <= 1'b0;
            n_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            c_reg     <= c_next;
            z_reg     <= z_next;
            n_reg     <= n_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        c_next     = c_reg;
        z_next     = z_reg;
        n_next     = n_reg;
        err_next   = 1'b0;

        case (state_reg)
            st_idle: begin
                // exec has priority; a concurrent ld_a is dropped even when
                // the opcode turns out to be illegal.
                if (bus.exec) begin
                    if (!bus.exec_op[3]) begin
                        b_next     = bus.bus_in;
                        op_next    = bus.exec_op;
                        state_next = st_calc;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (bus.ld_a) begin
                    a_next = bus.bus_in;
                end
            end
            st_calc: begin
                // Carry lives only in flag_c; A keeps the low 16 bits.
                a_next     = bus.alu_res[15:0];
                c_next     = bus.alu_res[16];
                z_next     = (bus.alu_res[15:0] == 16'h0000);
                n_next     = bus.alu_res[15];
                state_next = st_done;
            end
            st_done: begin
                state_next = st_idle;
            end
            default: begin
                state_next = st_idle;
            end
        endcase

        // Handshake outputs are registered copies of the next-state decode.
        busy_next = (state_next != st_idle);
        done_next = (state_next == st_done);
    end

    assign bus.alu_a   = a_reg;
    assign bus.alu_b   = b_reg;
    assign bus.alu_op  = op_reg;
    assign bus.acc_out = a_reg;
    assign bus.flag_c  = c_reg;
    assign bus.flag_z  = z_reg;
    assign bus.flag_n  = n_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.err     = err_reg;
endmodule

// File: tb/tb_alu_reg_stage.sv
// Scoreboard bench for alu_reg_stage: a behavioural ALU feeds alu_res, the
// stimulus thread queues expected writebacks, a monitor checks each done.
`timescale 1ns/1ps
module tb_alu_reg_stage;
    logic clk = 1'b0;
    logic rst;
    alu_reg_stage_if ifc();

    alu_reg_stage dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected writeback: {A, C, Z, N}
    logic [18:0] exp_q[$];

    logic [15:0] model_a, model_b;
    logic [3:0]  model_op;
    logic        model_c, model_z, model_n;

    logic        force_en  = 1'b0;
    logic [16:0] force_val = 17'h0;

    function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op);
        case (op[2:0])
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {a, 1'b0};
            default: return {2'b00, a[15:1]};
        endcase
    endfunction

    // ALU environment, optionally overridden to force a specific result.
    always_comb begin
        ifc.alu_res = force_en ? force_val : alu_fn(ifc.alu_a, ifc.alu_b, ifc.alu_op);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued writeback.
    always @(negedge clk) begin
        if (!rst && ifc.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(ifc.done), 32'd0);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check("writeback", {13'd0, ifc.acc_out, ifc.flag_c, ifc.flag_z, ifc.flag_n},
                      {13'd0, e});
                $display("[TB] done: A=0x%04h C=%0b Z=%0b N=%0b (exp 0x%04h %0b%0b%0b)",
                         ifc.acc_out, ifc.flag_c, ifc.flag_z, ifc.flag_n,
                         e[18:3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic model_reset();
        model_a = 0; model_b = 0; model_op = 0;
        model_c = 0; model_z = 0; model_n = 0;
    endtask

    task automatic do_ld(input logic [15:0] val);
        @(negedge clk);
        ifc.ld_a = 1'b1; ifc.bus_in = val;
        @(posedge clk); #1;
        ifc.ld_a = 1'b0;
        model_a = val;
        check("ld_a_value", 32'(ifc.acc_out), 32'(model_a));
        check("ld_flags", {29'd0, ifc.flag_c, ifc.flag_z, ifc.flag_n},
              {29'd0, model_c, model_z, model_n});
        $display("[TB] ld_a 0x%04h -> A=0x%04h", val, ifc.acc_out);
    endtask

    task automatic do_illegal(input logic [3:0] op, input logic with_ld);
        @(negedge clk);
        ifc.exec = 1'b1; ifc.exec_op = op; ifc.ld_a = with_ld;
        ifc.bus_in = 16'($urandom);
        @(posedge clk); #1;
        ifc.exec = 1'b0; ifc.ld_a = 1'b0;
        check("err_pulse", 32'(ifc.err), 32'd1);
        check("illegal_busy", 32'(ifc.busy), 32'd0);
        check("illegal_state", {ifc.acc_out, ifc.alu_b}, {model_a, model_b});
        check("illegal_flags", {25'd0, ifc.alu_op, ifc.flag_c, ifc.flag_z, ifc.flag_n},
              {25'd0, model_op, model_c, model_z, model_n});
        @(posedge clk); #1;
        check("err_one_cycle", 32'(ifc.err), 32'd0);
        $display("[TB] illegal op %0d (ld_a=%0b) -> err pulse, A=0x%04h", op, with_ld, ifc.acc_out);
    endtask

    task automatic do_exec(input logic [3:0] op, input logic [15:0] val,
                           input logic with_ld, input logic exec_in_done);
        logic [16:0] res;
        int busy_cycles, done_cycles;
        res = force_en ? force_val : alu_fn(model_a, val, op);
        @(negedge clk);
        ifc.exec = 1'b1; ifc.exec_op = op; ifc.bus_in = val; ifc.ld_a = with_ld;
        model_b = val; model_op = op;
        model_a = res[15:0]; model_c = res[16];
        model_z = (res[15:0] == 16'h0); model_n = res[15];
        exp_q.push_back({model_a, model_c, model_z, model_n});
        @(posedge clk); #1;
        ifc.exec = 1'b0; ifc.ld_a = 1'b0;
        check("e0_alu_b", 32'(ifc.alu_b), 32'(val));
        check("e0_alu_op", 32'(ifc.alu_op), 32'(op));
        check("e0_busy", 32'(ifc.busy), 32'd1);
        busy_cycles = 1; done_cycles = 0;
        for (int i = 0; i < 6 && ifc.busy; i++) begin
            @(posedge clk); #1;
            ifc.exec = 1'b0;
            if (ifc.busy) busy_cycles++;
            if (ifc.done) begin
                done_cycles++;
                if (exec_in_done) begin
                    ifc.exec = 1'b1; ifc.exec_op = 4'd2; ifc.bus_in = ~val;
                end
            end
        end
        ifc.exec = 1'b0;
        check("busy_cycles", 32'(busy_cycles), 32'd2);
        check("done_cycles", 32'(done_cycles), 32'd1);
        if (exec_in_done) begin
            @(posedge clk); #1;
            check("done_exec_ignored", {15'd0, ifc.busy, ifc.alu_b}, {15'd0, 1'b0, model_b});
        end
        $display("[TB] exec op %0d bus 0x%04h ld=%0b -> A=0x%04h busy=%0d done=%0d",
                 op, val, with_ld, ifc.acc_out, busy_cycles, done_cycles);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ifc.bus_in = 0; ifc.ld_a = 0; ifc.exec = 0; ifc.exec_op = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", {ifc.acc_out, ifc.alu_b}, 32'd0);
        check("reset_ctrl", {22'd0, ifc.alu_op, ifc.flag_c, ifc.flag_z, ifc.flag_n,
                             ifc.busy, ifc.done, ifc.err}, 32'd0);

        // Asynchronous reset mid-cycle with A preloaded.
        do_ld(16'h1234);
        @(negedge clk); #2;
        rst = 1'b1; #1;
        check("async_reset_a", 32'(ifc.acc_out), 32'd0);
        check("async_reset_alu_a", 32'(ifc.alu_a), 32'd0);
        model_reset();
        @(negedge clk); rst = 1'b0;
        $display("[TB] async reset -> A=0x%04h", ifc.acc_out);

        do_ld(16'h0005);
        do_exec(4'd0, 16'h0003, 1'b0, 1'b0);
        do_ld(16'h0003);
        do_exec(4'd1, 16'h0003, 1'b0, 1'b0);
        do_ld(16'h7FFF);
        do_exec(4'd0, 16'h0001, 1'b0, 1'b0);

        force_en = 1'b1; force_val = 17'h10000;
        do_exec(4'd0, 16'h00AA, 1'b0, 1'b0);
        force_en = 1'b0;
        do_ld(16'h0042);

        do_illegal(4'd9, 1'b0);
        do_illegal(4'd15, 1'b1);
        do_exec(4'd4, 16'h0F0F, 1'b1, 1'b0);
        do_exec(4'd3, 16'h1000, 1'b0, 1'b1);

        // Reset while in CALC: no writeback, no done.
        @(negedge clk);
        ifc.exec = 1'b1; ifc.exec_op = 4'd0; ifc.bus_in = 16'h0101;
        @(posedge clk); #1;
        ifc.exec = 1'b0;
        #2 rst = 1'b1; #1;
        check("calc_reset_outputs", {ifc.acc_out, ifc.alu_b}, 32'd0);
        check("calc_reset_ctrl", {22'd0, ifc.alu_op, ifc.flag_c, ifc.flag_z, ifc.flag_n,
                                  ifc.busy, ifc.done, ifc.err}, 32'd0);
        model_reset();
        @(negedge clk); rst = 1'b0;
        begin
            int dn;
            dn = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (ifc.done) dn++;
            end
            check("calc_reset_no_done", 32'(dn), 32'd0);
        end
        $display("[TB] reset in CALC -> A=0x%04h busy=%0b", ifc.acc_out, ifc.busy);
        do_exec(4'd0, 16'h0021, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)       do_ld(16'($urandom));
            else if (r == 3) do_illegal(4'(8 + $urandom_range(0, 7)), 1'($urandom));
            else             do_exec(4'($urandom_range(0, 7)), 16'($urandom),
                                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
